// File: rtl/core5_cpu_1_oci_dct_packer_if.sv
// ============================================================================
// core5_cpu_1_oci_dct_packer_if : trace-symbol, live-buffer and frame signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface core5_cpu_1_oci_dct_packer_if #(
    parameter int SLOT_W = 2,
    parameter int SLOTS  = 15
);
    localparam int BUF_W = SLOT_W * SLOTS;

    logic              sym_valid;
    logic [SLOT_W-1:0] sym_data;
    logic              test_ending;
    logic              frame_ready;

    logic [BUF_W-1:0]  dct_buffer;
    logic [3:0]        dct_count;
    logic              frame_valid;
    logic [BUF_W-1:0]  frame_data;
    logic [3:0]        frame_count;
    logic              overflow;
    logic              test_has_ended;
    logic [7:0]        drop_count;

    modport master (
        output sym_valid, sym_data, test_ending, frame_ready,
        input  dct_buffer, dct_count, frame_valid, frame_data, frame_count,
               overflow, test_has_ended, drop_count
    );

    modport slave (
        input  sym_valid, sym_data, test_ending, frame_ready,
        output dct_buffer, dct_count, frame_valid, frame_data, frame_count,
               overflow, test_has_ended, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/core5_cpu_1_oci_dct_packer.sv
// ============================================================================
// core5_cpu_1_oci_dct_packer : packs 2-bit trace symbols into 30-bit frames
// with a one-deep valid/ready frame register and a RUN/FLUSH/DONE flush FSM.
// Optional feature macro: CORE5_DCT_DROP_COUNT_EN (saturating drop counter).
// Revision: 1.0
// ============================================================================
`default_nettype none

module core5_cpu_1_oci_dct_packer #(
    parameter int SLOT_W = 2,
    parameter int SLOTS  = 15
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    core5_cpu_1_oci_dct_packer_if.slave    dct_if
);
    localparam int         BUF_W    = SLOT_W * SLOTS;
    localparam logic [3:0] FULL_CNT = 4'(SLOTS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic [BUF_W-1:0]   buf_q,    buf_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic               fvalid_q, fvalid_d;
    logic [BUF_W-1:0]   fdata_q,  fdata_d;
    logic [3:0]         fcnt_q,   fcnt_d;
    logic               ovf_q,    ovf_d;
    logic               ended_q,  ended_d;

    logic               frame_free;
    logic               xfer;
    logic               accept;
    logic               drop;
    logic [3:0]         slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            buf_q    <= '0;
            cnt_q    <= '0;
            fvalid_q <= 1'b0;
            fdata_q  <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
            ended_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            fvalid_q <= fvalid_d;
            fdata_q  <= fdata_d;
            fcnt_q   <= fcnt_d;
            ovf_q    <= ovf_d;
            ended_q  <= ended_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fvalid_d   = fvalid_q;
        fdata_d    = fdata_q;
        fcnt_d     = fcnt_q;
        ovf_d      = ovf_q;
        ended_d    = ended_q;
        frame_free = !fvalid_q || dct_if.frame_ready;
        xfer       = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;

        case (state_q)
            ST_RUN: begin
                xfer   = frame_free && (cnt_q == FULL_CNT);
                // A full buffer only takes a new symbol when it empties this same cycle.
                accept = dct_if.sym_valid && ((cnt_q != FULL_CNT) || xfer);
                drop   = dct_if.sym_valid && !accept;
                if (dct_if.test_ending) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                xfer = frame_free && (cnt_q != 4'd0);
                if ((cnt_q == 4'd0) && !fvalid_q) begin
                    state_d = ST_DONE;
                    ended_d = 1'b1;
                end
            end
            ST_DONE: begin
                ended_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (fvalid_q && dct_if.frame_ready) begin
            fvalid_d = 1'b0;
        end

        if (xfer) begin
            fvalid_d = 1'b1;
            fdata_d  = buf_q;
            fcnt_d   = cnt_q;
            buf_d    = '0;
            cnt_d    = '0;
        end

        slot = xfer ? 4'd0 : cnt_q;
        if (accept) begin
            for (int n = 0; n < SLOTS; n++) begin
                if (slot == 4'(n)) begin
                    buf_d[n*SLOT_W +: SLOT_W] = dct_if.sym_data;
                end
            end
            cnt_d = slot + 4'd1;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef CORE5_DCT_DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign dct_if.drop_count = drop_cnt_q;
`else
    assign dct_if.drop_count = '0;
`endif

    assign dct_if.dct_buffer     = buf_q;
    assign dct_if.dct_count      = cnt_q;
    assign dct_if.frame_valid    = fvalid_q;
    assign dct_if.frame_data     = fdata_q;
    assign dct_if.frame_count    = fcnt_q;
    assign dct_if.overflow       = ovf_q;
    assign dct_if.test_has_ended = ended_q;

endmodule

`default_nettype wire

// File: tb/tb_core5_cpu_1_oci_dct_packer.sv
// ============================================================================
// tb_core5_cpu_1_oci_dct_packer : directed self-checking bench for the DCT packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core5_cpu_1_oci_dct_packer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    core5_cpu_1_oci_dct_packer_if #(.SLOT_W(2), .SLOTS(15)) dif ();

    core5_cpu_1_oci_dct_packer #(.SLOT_W(2), .SLOTS(15)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dct_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] d);
        dif.sym_valid = 1'b1;
        dif.sym_data  = d;
        tick();
    endtask

    task automatic idle();
        dif.sym_valid = 1'b0;
        dif.sym_data  = 2'b00;
        tick();
    endtask

    task automatic do_reset();
        dif.sym_valid   = 1'b0;
        dif.sym_data    = 2'b00;
        dif.test_ending = 1'b0;
        dif.frame_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_buf"},   32'(dif.dct_buffer),     32'h0);
        check_eq({tag, "_cnt"},   32'(dif.dct_count),      32'h0);
        check_eq({tag, "_fv"},    32'(dif.frame_valid),    32'h0);
        check_eq({tag, "_fd"},    32'(dif.frame_data),     32'h0);
        check_eq({tag, "_fc"},    32'(dif.frame_count),    32'h0);
        check_eq({tag, "_ovf"},   32'(dif.overflow),       32'h0);
        check_eq({tag, "_end"},   32'(dif.test_has_ended), 32'h0);
        check_eq({tag, "_drops"}, 32'(dif.drop_count),     32'h0);
    endtask

    initial begin
        logic [7:0] exp_drops;
        n_checks = 0;
        n_fail   = 0;
`ifdef CORE5_DCT_DROP_COUNT_EN
        exp_drops = 8'd1;
`else
        exp_drops = 8'd0;
`endif

        // Reset state
        do_reset();
        check_all_zero("rst");

        // Full frame with slot n = n mod 4
        for (int i = 0; i < 15; i++) sym(2'(i % 4));
        check_eq("full_cnt",    32'(dif.dct_count),   32'd15);
        check_eq("full_buf",    32'(dif.dct_buffer),  32'h24E4E4E4);
        check_eq("full_fv_pre", 32'(dif.frame_valid), 32'd0);
        idle();
        check_eq("xfer_fv",  32'(dif.frame_valid), 32'd1);
        check_eq("xfer_fd",  32'(dif.frame_data),  32'h24E4E4E4);
        check_eq("xfer_fc",  32'(dif.frame_count), 32'd15);
        check_eq("xfer_cnt", 32'(dif.dct_count),   32'd0);
        check_eq("xfer_buf", 32'(dif.dct_buffer),  32'd0);
        idle();
        check_eq("consumed_fv", 32'(dif.frame_valid), 32'd0);

        // 16th symbol arriving in the transfer cycle
        do_reset();
        for (int i = 0; i < 15; i++) sym(2'b01);
        sym(2'b11);
        check_eq("s16_fv",  32'(dif.frame_valid), 32'd1);
        check_eq("s16_fd",  32'(dif.frame_data),  32'h15555555);
        check_eq("s16_fc",  32'(dif.frame_count), 32'd15);
        check_eq("s16_cnt", 32'(dif.dct_count),   32'd1);
        check_eq("s16_buf", 32'(dif.dct_buffer),  32'h3);

        // Back-pressure: 31 symbols of 2'b11 with frame_ready low
        do_reset();
        dif.frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) sym(2'b11);
        check_eq("bp_fv",     32'(dif.frame_valid), 32'd1);
        check_eq("bp_fd",     32'(dif.frame_data),  32'h3FFFFFFF);
        check_eq("bp_cnt",    32'(dif.dct_count),   32'd15);
        check_eq("bp_ovf0",   32'(dif.overflow),    32'd0);
        sym(2'b11);
        check_eq("drop_ovf",   32'(dif.overflow),   32'd1);
        check_eq("drop_count", 32'(dif.drop_count), 32'(exp_drops));
        check_eq("drop_cnt",   32'(dif.dct_count),  32'd15);
        check_eq("drop_buf",   32'(dif.dct_buffer), 32'h3FFFFFFF);
        check_eq("drop_fd",    32'(dif.frame_data), 32'h3FFFFFFF);
        check_eq("drop_fc",    32'(dif.frame_count), 32'd15);
        dif.frame_ready = 1'b1;
        idle();
        check_eq("b2b_fv",  32'(dif.frame_valid), 32'd1);
        check_eq("b2b_cnt", 32'(dif.dct_count),   32'd0);
        check_eq("b2b_ovf", 32'(dif.overflow),    32'd1);

        // Asynchronous reset mid-frame with 7 slots filled
        do_reset();
        dif.frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) sym(2'b01);
        check_eq("pre_rst_fv",  32'(dif.frame_valid), 32'd1);
        check_eq("pre_rst_cnt", 32'(dif.dct_count),   32'd7);
        dif.sym_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.frame_ready = 1'b1;
        sym(2'b10);
        check_eq("restart_buf", 32'(dif.dct_buffer), 32'h2);
        check_eq("restart_cnt", 32'(dif.dct_count),  32'd1);

        // Flush: 5 symbols of 2'b10, the 5th coinciding with test_ending
        do_reset();
        for (int i = 0; i < 4; i++) sym(2'b10);
        dif.test_ending = 1'b1;
        sym(2'b10);
        dif.test_ending = 1'b0;
        check_eq("fl_cnt", 32'(dif.dct_count),   32'd5);
        check_eq("fl_buf", 32'(dif.dct_buffer),  32'h2AA);
        check_eq("fl_fv0", 32'(dif.frame_valid), 32'd0);
        sym(2'b11);
        check_eq("fl_fv",  32'(dif.frame_valid),    32'd1);
        check_eq("fl_fd",  32'(dif.frame_data),     32'h2AA);
        check_eq("fl_fc",  32'(dif.frame_count),    32'd5);
        check_eq("fl_cnt1", 32'(dif.dct_count),     32'd0);
        sym(2'b11);
        check_eq("fl_fv_done", 32'(dif.frame_valid),    32'd0);
        check_eq("fl_end0",    32'(dif.test_has_ended), 32'd0);
        sym(2'b11);
        check_eq("fl_end1",    32'(dif.test_has_ended), 32'd1);
        check_eq("fl_ign_cnt", 32'(dif.dct_count),      32'd0);
        check_eq("fl_ign_ovf", 32'(dif.overflow),       32'd0);
        for (int i = 0; i < 20; i++) sym(2'b11);
        check_eq("done_cnt", 32'(dif.dct_count),      32'd0);
        check_eq("done_fv",  32'(dif.frame_valid),    32'd0);
        check_eq("done_end", 32'(dif.test_has_ended), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
